// File: rtl/processor_pkg.sv
// processor_pkg: shared fetch/decode types, default widths and halt encoding
package processor_pkg;
  localparam int ADDR_W = 10;
  localparam int WORD_W = 9;
  localparam logic [WORD_W-1:0] HALT_INSTR = '1;
  typedef enum logic [1:0] {IDLE, FETCH, HALTED} fetch_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: N-bit up counter that saturates at all-ones, sync clear
// ports: clk, rst (sync active-high), inc (count enable), clr (sync clear), count
module sat_counter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [N-1:0] count
);
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (inc && count != {N{1'b1}}) count <= count + 1'b1;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetch stage registering ROM words into the IR with squash, halt and runaway detection
// ports: clk, reset (sync active-high), start (tb handshake), pog_ctr (PC), branch_en (decode branch),
//        rom_addr/rom_data (async ROM), instr/instr_pc/instr_valid (IR), done (program finished)
// optional INST_FETCH_PERF_EN adds perf_fetched / perf_squashed saturating counters
module inst_fetch #(
  parameter int A = processor_pkg::ADDR_W,
  parameter int W = processor_pkg::WORD_W,
  parameter logic [W-1:0] HALT_INSTR = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [A-1:0] pog_ctr,
  input  logic         branch_en,
  output logic [A-1:0] rom_addr,
  input  logic [W-1:0] rom_data,
  output logic [W-1:0] instr,
  output logic [A-1:0] instr_pc,
  output logic         instr_valid,
  output logic         done
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [15:0]  perf_fetched,
  output logic [15:0]  perf_squashed
`endif
);
  import processor_pkg::*;
  fetch_state_t state, state_nxt;
  logic start_q, start_fall, start_rise, halt_hit, runaway, capture;
  assign rom_addr   = pog_ctr;
  assign start_fall = start_q & ~start;
  assign start_rise = start & ~start_q;
  assign halt_hit   = instr_valid && instr == HALT_INSTR;
  // the last address was issued and decode did not redirect, so the next fetch would wrap to 0
  assign runaway    = instr_valid && instr_pc == {A{1'b1}} && !branch_en;
  always_ff @(posedge clk) start_q <= start;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = (state == IDLE)  ? (start_fall ? FETCH : IDLE) :
                (state == FETCH) ? (start ? IDLE : (halt_hit || runaway) ? HALTED : FETCH) :
                (start_rise ? IDLE : HALTED);
  end
  always_comb begin
    capture = state == FETCH && state_nxt == FETCH;
    done    = state == HALTED;
  end
  // a branch decided on the current IR means the word now on rom_data is the fall-through, so squash it
  always_ff @(posedge clk)
    if (reset) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (capture) begin
        instr    <= rom_data;
        instr_pc <= pog_ctr;
      end
      instr_valid <= capture && !branch_en;
    end
`ifdef INST_FETCH_PERF_EN
  logic perf_clr;
  assign perf_clr = state == IDLE && state_nxt == FETCH;
  sat_counter #(.N(16)) u_fetched (
    .clk   (clk),
    .rst   (reset),
    .inc   (capture && !branch_en),
    .clr   (perf_clr),
    .count (perf_fetched)
  );
  sat_counter #(.N(16)) u_squashed (
    .clk   (clk),
    .rst   (reset),
    .inc   (state == FETCH && branch_en),
    .clr   (perf_clr),
    .count (perf_squashed)
  );
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: table-driven directed bench for inst_fetch
module tb_inst_fetch;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] pog_ctr = '0;
  logic       branch_en = 1'b0;
  logic [9:0] rom_addr;
  logic [8:0] rom_data;
  logic [8:0] instr;
  logic [9:0] instr_pc;
  logic       instr_valid;
  logic       done;
`ifdef INST_FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_squashed;
`endif
  logic [8:0] rom [1024];
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  inst_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pog_ctr     (pog_ctr),
    .branch_en   (branch_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .done        (done)
`ifdef INST_FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_squashed (perf_squashed)
`endif
  );

  typedef struct {
    logic       rst;
    logic       st;
    logic [9:0] pc;
    logic       br;
    logic [8:0] ei;
    logic [9:0] ep;
    logic       ev;
    logic       ed;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic st, logic [9:0] pc, logic br,
                              logic [8:0] ei, logic [9:0] ep, logic ev, logic ed);
    vec_t v;
    v.rst = rst; v.st = st; v.pc = pc; v.br = br;
    v.ei = ei; v.ep = ep; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  task automatic chk(string nm, int row, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, got, exp);
    end
  endtask

  task automatic step(logic r, logic s, logic [9:0] p, logic b);
    reset = r; start = s; pog_ctr = p; branch_en = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(int row, logic [8:0] ei, logic [9:0] ep, logic ev, logic ed);
    chk("instr", row, 32'(instr), 32'(ei));
    chk("instr_pc", row, 32'(instr_pc), 32'(ep));
    chk("instr_valid", row, 32'(instr_valid), 32'(ev));
    chk("done", row, 32'(done), 32'(ed));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = {1'b0, 8'(i)};
    rom[0] = 9'h012; rom[1] = 9'h034; rom[2] = 9'h056; rom[3] = 9'h1FF;
    rom[5] = 9'h055; rom[20] = 9'h0AA;
    vecs.push_back(mk(1, 0, 10'd0,   0, 9'h000, 10'd0,   0, 0));
    vecs.push_back(mk(1, 0, 10'd0,   0, 9'h000, 10'd0,   0, 0));
    vecs.push_back(mk(0, 1, 10'd0,   0, 9'h000, 10'd0,   0, 0));
    vecs.push_back(mk(0, 1, 10'd0,   0, 9'h000, 10'd0,   0, 0));
    vecs.push_back(mk(0, 1, 10'd0,   0, 9'h000, 10'd0,   0, 0));
    vecs.push_back(mk(0, 0, 10'd0,   0, 9'h000, 10'd0,   0, 0));
    vecs.push_back(mk(0, 0, 10'd0,   0, 9'h012, 10'd0,   1, 0));
    vecs.push_back(mk(0, 0, 10'd1,   0, 9'h034, 10'd1,   1, 0));
    vecs.push_back(mk(0, 0, 10'd2,   0, 9'h056, 10'd2,   1, 0));
    vecs.push_back(mk(0, 0, 10'd3,   0, 9'h1FF, 10'd3,   1, 0));
    vecs.push_back(mk(0, 0, 10'd4,   0, 9'h1FF, 10'd3,   0, 1));
    vecs.push_back(mk(0, 0, 10'd5,   1, 9'h1FF, 10'd3,   0, 1));
    vecs.push_back(mk(0, 1, 10'd0,   0, 9'h1FF, 10'd3,   0, 0));
    vecs.push_back(mk(0, 0, 10'd4,   0, 9'h1FF, 10'd3,   0, 0));
    vecs.push_back(mk(0, 0, 10'd4,   0, 9'h004, 10'd4,   1, 0));
    vecs.push_back(mk(0, 0, 10'd5,   1, 9'h055, 10'd5,   0, 0));
    vecs.push_back(mk(0, 0, 10'd20,  0, 9'h0AA, 10'd20,  1, 0));
    vecs.push_back(mk(0, 0, 10'd21,  0, 9'h015, 10'd21,  1, 0));
    vecs.push_back(mk(0, 0, 10'd7,   0, 9'h007, 10'd7,   1, 0));
    vecs.push_back(mk(1, 0, 10'd8,   0, 9'h000, 10'd0,   0, 0));
    vecs.push_back(mk(0, 1, 10'd6,   0, 9'h000, 10'd0,   0, 0));
    vecs.push_back(mk(0, 0, 10'd6,   0, 9'h000, 10'd0,   0, 0));
    vecs.push_back(mk(0, 0, 10'd7,   0, 9'h007, 10'd7,   1, 0));
    vecs.push_back(mk(0, 1, 10'd8,   0, 9'h007, 10'd7,   0, 0));
    vecs.push_back(mk(0, 1, 10'd8,   0, 9'h007, 10'd7,   0, 0));
    vecs.push_back(mk(0, 0, 10'h3FD, 0, 9'h007, 10'd7,   0, 0));
    vecs.push_back(mk(0, 0, 10'h3FD, 0, 9'h0FD, 10'h3FD, 1, 0));
    vecs.push_back(mk(0, 0, 10'h3FE, 0, 9'h0FE, 10'h3FE, 1, 0));
    vecs.push_back(mk(0, 0, 10'h3FF, 0, 9'h0FF, 10'h3FF, 1, 0));
    vecs.push_back(mk(0, 0, 10'd0,   0, 9'h0FF, 10'h3FF, 0, 1));
    vecs.push_back(mk(0, 0, 10'd1,   0, 9'h0FF, 10'h3FF, 0, 1));
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].pc, vecs[i].br);
      chk_out(i, vecs[i].ei, vecs[i].ep, vecs[i].ev, vecs[i].ed);
      if (i == 11)
        for (int k = 0; k < 10; k++) begin
          step(0, 0, 10'(k + 6), k[0]);
          chk_out(100 + k, 9'h1FF, 10'd3, 0, 1);
        end
    end
`ifdef INST_FETCH_PERF_EN
    step(1, 0, 10'd0, 0);
    chk("perf_fetched_rst", 200, 32'(perf_fetched), 32'd0);
    step(0, 1, 10'd10, 0);
    step(0, 0, 10'd10, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 10'(k + 10), (k == 2 || k == 5));
    chk("perf_fetched", 201, 32'(perf_fetched), 32'd6);
    chk("perf_squashed", 201, 32'(perf_squashed), 32'd2);
    for (int k = 0; k < 70000; k++) step(0, 0, 10'(k % 1000), 0);
    chk("perf_fetched_sat", 202, 32'(perf_fetched), 32'hFFFF);
    chk("perf_squashed_hold", 202, 32'(perf_squashed), 32'd2);
    step(1, 0, 10'd0, 0);
    chk("perf_fetched_clr", 203, 32'(perf_fetched), 32'd0);
    chk("perf_squashed_clr", 203, 32'(perf_squashed), 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
